// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter for the register-file write port between the ALU and load
// write-back paths, plus a per-register busy scoreboard for issue-time stall checks.
module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_rd,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_value,
  output logic              rf_regwrite,
  output logic              last_grant
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  req_id_t           last_q;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Contention goes to whichever requester did not win last; ready implies valid.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (last_q == REQ1));
    grant1 = req1_valid && (!req0_valid || (last_q == REQ0));
    xfer   = grant0 || grant1;
    win_rd   = grant1 ? req1_rd   : req0_rd;
    win_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign last_grant = last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ1;
    end else if (xfer) begin
      last_q <= grant1 ? REQ1 : REQ0;
    end
  end

  // Write stage: register-0 writes are accepted but never enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_regwrite    <= 1'b0;
      rf_rd          <= '0;
      rf_write_value <= '0;
    end else begin
      rf_regwrite <= xfer && (win_rd != '0);
      if (xfer) begin
        rf_rd          <= win_rd;
        rf_write_value <= win_data;
      end
    end
  end

  // Clear first, then set, so a same-edge reservation of the written register survives.
  always_comb begin
    busy_d = busy_q;
    if (rf_regwrite) begin
      busy_d[rf_rd] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != '0)) begin
      busy_d[rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // The register file writes through, so the in-flight write hides its own busy bit.
  always_comb begin
    rs_busy = (chk_rs != '0) && busy_q[chk_rs] && !(rf_regwrite && (rf_rd == chk_rs));
    rt_busy = (chk_rt != '0) && busy_q[chk_rt] && !(rf_regwrite && (rf_rd == chk_rt));
  end

endmodule
